eth_rx_framer: RTL and testbench

- Upstream neighbour of the RGB byte converter (cnv8to24).
- Takes the raw GMII receive byte stream, validates preamble/SFD, strips the 4-byte FCS, and emits the frame body as a contiguous `data8b`/`en` burst. The burst runs from destination MAC to the last byte before FCS.
- Also flags malformed frames and keeps saturating frame/error counters for debug readout.

---
 rtl/eth_rx_framer.sv | 188 ++++++++++++++++++
 tb/tb_eth_rx_framer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_framer.sv
// GMII receive framer: checks preamble/SFD, drops the trailing FCS and emits the frame body as a contiguous en burst.
// The body is delayed 4 sampled bytes when FCS stripping is on. There is no backpressure: the GMII stream cannot be stalled.
module eth_rx_framer #(
  parameter int MIN_PREAMBLE = 5,
  parameter int STRIP_FCS    = 1,
  parameter int MAX_LEN      = 1518
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic [7:0]  data8b,
  output logic        en,
  output logic        sof,
  output logic        eof,
  output logic        frame_bad,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_PAY  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [3:0][7:0] dl_q, dl_d;
  logic [2:0]      dl_cnt_q, dl_cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic            bad_q, bad_d;
  logic [7:0]      data_q, data_d;
  logic            en_q, en_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            fbad_q, fbad_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            inc_frm, inc_err;
  logic            emit_vld;
  logic [7:0]      emit_dat;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    dl_d     = dl_q;
    dl_cnt_d = dl_cnt_q;
    len_d    = len_q;
    bad_d    = bad_q;
    data_d   = data_q;
    en_d     = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    fbad_d   = 1'b0;
    inc_frm  = 1'b0;
    inc_err  = 1'b0;
    emit_vld = 1'b0;
    emit_dat = rxd;

    case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          if (rxd == 8'h55) begin
            state_d = S_PRE;
            pcnt_d  = 3'd1;
          end else begin
            state_d = S_DROP;
            inc_err = 1'b1;
          end
        end
      end

      S_PRE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
          inc_err = 1'b1;
        end else if (rxd == 8'h55) begin
          if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        end else if (rxd == 8'hD5 && pcnt_q >= 3'(MIN_PREAMBLE)) begin
          state_d  = S_PAY;
          dl_cnt_d = 3'd0;
          len_d    = '0;
          bad_d    = 1'b0;
        end else begin
          state_d = S_DROP;
          inc_err = 1'b1;
        end
      end

      S_PAY: begin
        if (rx_dv) begin
          if (rx_er) bad_d = 1'b1;
          // The oldest of four held bytes is released only once it is known not to be FCS.
          if (STRIP_FCS != 0) begin
            dl_d = {dl_q[2:0], rxd};
            if (dl_cnt_q == 3'd4) begin
              emit_vld = 1'b1;
              emit_dat = dl_q[3];
            end else begin
              dl_cnt_d = dl_cnt_q + 3'd1;
            end
          end else begin
            emit_vld = 1'b1;
          end

          if (emit_vld) begin
            if (len_q == LW'(MAX_LEN)) begin
              state_d = S_DROP;
              eof_d   = 1'b1;
              fbad_d  = 1'b1;
              inc_err = 1'b1;
            end else begin
              en_d   = 1'b1;
              sof_d  = (len_q == '0);
              data_d = emit_dat;
              len_d  = len_q + LW'(1);
            end
          end
        end else begin
          // A frame that emitted nothing is a runt and is reported bad.
          state_d  = S_IDLE;
          dl_cnt_d = 3'd0;
          eof_d    = 1'b1;
          fbad_d   = bad_q || (len_q == '0);
          inc_err  = fbad_d;
          inc_frm  = !fbad_d;
        end
      end

      S_DROP: begin
        if (!rx_dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (inc_frm && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
    if (inc_err && err_cnt_q != 16'hFFFF)   err_cnt_d   = err_cnt_q + 16'd1;
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pcnt_q      <= 3'd0;
      dl_q        <= '0;
      dl_cnt_q    <= 3'd0;
      len_q       <= '0;
      bad_q       <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      fbad_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      dl_q        <= dl_d;
      dl_cnt_q    <= dl_cnt_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      data_q      <= data_d;
      en_q        <= en_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      fbad_q      <= fbad_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data8b    = data_q;
  assign en        = en_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign frame_bad = fbad_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_eth_rx_framer.sv
// Bench for eth_rx_framer: two instances (full MAX_LEN and MAX_LEN=16) share one GMII stimulus stream.
// Expected bursts are queued per frame from the frame rules; a negedge monitor pops and compares.
module tb_eth_rx_framer;
  localparam int MIN_PRE = 5;
  localparam int MAXB    = 1518;
  localparam int MAXS    = 16;

  logic        dclk  = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd   = 8'h00;
  logic [7:0]  d0, d1;
  logic        en0, en1, sof0, sof1, eof0, eof1, bad0, bad1;
  logic [15:0] fc0, fc1, ec0, ec1;

  always #5 dclk = ~dclk;

  eth_rx_framer #(.MIN_PREAMBLE(MIN_PRE), .STRIP_FCS(1), .MAX_LEN(MAXB)) u_big (
    .dclk(dclk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .data8b(d0), .en(en0), .sof(sof0), .eof(eof0), .frame_bad(bad0),
    .frame_cnt(fc0), .err_cnt(ec0));

  eth_rx_framer #(.MIN_PREAMBLE(MIN_PRE), .STRIP_FCS(1), .MAX_LEN(MAXS)) u_small (
    .dclk(dclk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .data8b(d1), .en(en1), .sof(sof1), .eof(eof1), .frame_bad(bad1),
    .frame_cnt(fc1), .err_cnt(ec1));

  int         compared   = 0;
  int         mismatched = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int         exp_frm[2];
  int         exp_err[2];
  logic [7:0] pl[$];

  // Token encoding: {1'b0, sof, byte} for a body byte, 10'h200 good eof, 10'h300 bad eof.
  task automatic push(input int inst, input logic [9:0] tok);
    if (inst == 0) q0.push_back(tok);
    else           q1.push_back(tok);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic mon(input int inst, input logic en, input logic sof, input logic eof,
                     input logic bad, input logic [7:0] d);
    logic [9:0] got;
    logic [9:0] exp;
    if (en || eof || sof || bad) begin
      if (en)       got = {1'b0, sof, d};
      else if (eof) got = {1'b1, bad, 8'h00};
      else          got = 10'h3FF;
      compared++;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
        mismatched++;
        $display("FAIL mon%0d unexpected output: got %h expected nothing", inst, got);
      end else begin
        exp = (inst == 0) ? q0.pop_front() : q1.pop_front();
        if (got !== exp) begin
          mismatched++;
          $display("FAIL mon%0d: got %h expected %h", inst, got, exp);
        end
      end
    end
  endtask

  always @(negedge dclk) begin
    if (rst_n) begin
      mon(0, en0, sof0, eof0, bad0, d0);
      mon(1, en1, sof1, eof1, bad1, d1);
    end
  end

  // Reference: body = payload minus 4 trailing FCS bytes, truncated at maxlen.
  task automatic model(input int inst, input int maxlen, input int n55, input int sfd,
                       input int er_idx, input bit abort);
    int nb;
    int nemit;
    nb = pl.size();
    if (!(sfd == 'hD5 && n55 >= MIN_PRE)) begin
      exp_err[inst]++;
      return;
    end
    nemit = (nb > 4) ? nb - 4 : 0;
    for (int i = 0; i < nemit && i < maxlen; i++) push(inst, {1'b0, (i == 0), pl[i]});
    if (nemit > maxlen) begin
      push(inst, 10'h300);
      exp_err[inst]++;
      return;
    end
    if (abort) return;
    if (nemit == 0 || (er_idx >= 0 && er_idx < nb)) begin
      push(inst, 10'h300);
      exp_err[inst]++;
    end else begin
      push(inst, 10'h200);
      exp_frm[inst]++;
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
    @(posedge dclk);
    #1;
  endtask

  task automatic chk_cnt();
    chk("frame_cnt_big",   fc0, 16'(exp_frm[0]));
    chk("err_cnt_big",     ec0, 16'(exp_err[0]));
    chk("frame_cnt_small", fc1, 16'(exp_frm[1]));
    chk("err_cnt_small",   ec1, 16'(exp_err[1]));
  endtask

  task automatic send_frame(input int n55, input int sfd, input int er_idx, input int gap,
                            input bit abort);
    model(0, MAXB, n55, sfd, er_idx, abort);
    model(1, MAXS, n55, sfd, er_idx, abort);
    for (int i = 0; i < n55; i++) drive(1'b1, 1'($urandom_range(0, 1)), 8'h55);
    if (sfd >= 0) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 8'(sfd));
      for (int i = 0; i < pl.size(); i++) drive(1'b1, (i == er_idx), pl[i]);
    end
    if (!abort) begin
      for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'($urandom));
      chk_cnt();
    end
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n55, sfd, nb, er, r;
    exp_frm = '{0, 0};
    exp_err = '{0, 0};
    repeat (3) @(posedge dclk);
    #1;
    chk("rst_data8b", {8'h00, d0}, 16'h0000);
    chk("rst_en", {15'h0, en0}, 16'h0000);
    chk("rst_sof", {15'h0, sof0}, 16'h0000);
    chk("rst_eof", {15'h0, eof0}, 16'h0000);
    chk("rst_frame_bad", {15'h0, bad0}, 16'h0000);
    chk_cnt();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Good frame with 0xAA FCS
    fill_seq(64);
    for (int i = 0; i < 4; i++) pl.push_back(8'hAA);
    send_frame(7, 'hD5, -1, 3, 1'b0);
    // Short preamble
    fill_rand(10);
    send_frame(3, 'hD5, -1, 2, 1'b0);
    // Minimum preamble, rx_er on byte 10
    fill_seq(64);
    send_frame(5, 'hD5, 10, 2, 1'b0);
    // 40-byte frame: oversize in the small instance only
    fill_rand(40);
    send_frame(7, 'hD5, -1, 2, 1'b0);
    // Runt
    fill_rand(3);
    send_frame(5, 'hD5, -1, 2, 1'b0);
    // Empty body
    pl.delete();
    send_frame(6, 'hD5, -1, 1, 1'b0);
    // rx_er on the final FCS byte
    fill_rand(30);
    send_frame(7, 'hD5, 29, 2, 1'b0);
    // Preamble abandoned, then a bad byte after preamble
    fill_rand(5);
    send_frame(4, -1, -1, 1, 1'b0);
    send_frame(6, 'h12, -1, 1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      r   = $urandom_range(0, 7);
      sfd = (r == 0) ? 'h12 : (r == 1) ? -1 : 'hD5;
      n55 = $urandom_range((sfd < 0) ? 1 : 0, 9);
      nb  = $urandom_range(0, 69);
      er  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (nb > 0) ? nb - 1 : 0) : -1;
      fill_rand(nb);
      send_frame(n55, sfd, er, $urandom_range(1, 3), 1'b0);
    end

    // Back-to-back with a single idle cycle, then a frame cut by reset
    fill_rand(50);
    send_frame(7, 'hD5, -1, 1, 1'b0);
    fill_rand(12);
    send_frame(7, 'hD5, -1, 1, 1'b0);
    fill_rand(20);
    send_frame(7, 'hD5, -1, 0, 1'b1);
    @(negedge dclk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_en", {15'h0, en0}, 16'h0000);
    chk("arst_data8b", {8'h00, d0}, 16'h0000);
    chk("arst_sof", {15'h0, sof0}, 16'h0000);
    chk("arst_eof", {15'h0, eof0}, 16'h0000);
    chk("arst_frame_bad", {15'h0, bad0}, 16'h0000);
    chk("arst_en_small", {15'h0, en1}, 16'h0000);
    exp_frm = '{0, 0};
    exp_err = '{0, 0};
    chk_cnt();
    rx_dv = 1'b1;
    rx_er = 1'b0;
    rxd   = 8'h33;
    @(posedge dclk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h33);
    drive(1'b1, 1'b0, 8'h33);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    exp_err = '{1, 1};
    chk_cnt();
    fill_rand(24);
    send_frame(7, 'hD5, -1, 3, 1'b0);

    repeat (10) @(posedge dclk);
    #1;
    chk("pending_big", 16'(q0.size()), 16'h0000);
    chk("pending_small", 16'(q1.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
